// File: rtl/world_stream_decoder_pkg.sv
// Shared constants, state encoding and helpers for the world-data stream decoder.
package world_stream_decoder_pkg;

  localparam int unsigned BLOCK_BITS_DEFAULT = 5;

  typedef logic [BLOCK_BITS_DEFAULT-1:0] block_t;

  localparam logic [7:0] WS_SYNC      = 8'hA5;
  localparam logic [7:0] WS_OP_SINGLE = 8'h01;
  localparam logic [7:0] WS_OP_RUN    = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPC,
    ST_X,
    ST_Y,
    ST_Z,
    ST_CNT,
    ST_BLK,
    ST_CHK,
    ST_WRITE
  } ws_state_e;

  function automatic logic is_valid_op(input logic [7:0] op);
    return (op == WS_OP_SINGLE) || (op == WS_OP_RUN);
  endfunction

endpackage

// File: rtl/world_stream_decoder_voxel_coord_stepper.sv
// Voxel coordinate register: loads a start point, steps y fastest, then x, then z,
// and flags when the current coordinate is the last voxel of the volume.
module voxel_coord_stepper #(
  parameter int unsigned LENGTH = 64,
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [$clog2(LENGTH)-1:0] x_start,
  input  logic [$clog2(WIDTH)-1:0]  y_start,
  input  logic [$clog2(HEIGHT)-1:0] z_start,
  output logic [$clog2(LENGTH)-1:0] x,
  output logic [$clog2(WIDTH)-1:0]  y,
  output logic [$clog2(HEIGHT)-1:0] z,
  output logic                      last_c
);

  localparam int unsigned XW = $clog2(LENGTH);
  localparam int unsigned YW = $clog2(WIDTH);
  localparam int unsigned ZW = $clog2(HEIGHT);

  logic x_end, y_end, z_end;

  assign x_end  = (x == XW'(LENGTH - 1));
  assign y_end  = (y == YW'(WIDTH - 1));
  assign z_end  = (z == ZW'(HEIGHT - 1));
  assign last_c = x_end && y_end && z_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (load) begin
      x <= x_start;
      y <= y_start;
      z <= z_start;
    end else if (step) begin
      if (y_end) begin
        y <= '0;
        if (x_end) begin
          x <= '0;
          z <= z + ZW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end else begin
        y <= y + YW'(1);
      end
    end
  end

endmodule

// File: rtl/world_stream_decoder.sv
// Parses framed world-data packets from the UART byte stream and issues
// validated single or run-length writes to the cache write port.
module world_stream_decoder
  import world_stream_decoder_pkg::*;
#(
  parameter int unsigned LENGTH         = 64,
  parameter int unsigned WIDTH          = 64,
  parameter int unsigned HEIGHT         = 16,
  parameter int unsigned BLOCK_BITS     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [7:0]                byte_in,
  input  logic                      byte_valid_in,
  output logic [$clog2(LENGTH)-1:0] x_out,
  output logic [$clog2(WIDTH)-1:0]  y_out,
  output logic [$clog2(HEIGHT)-1:0] z_out,
  output logic [BLOCK_BITS-1:0]     block_out,
  output logic                      write_valid_out,
  input  logic                      write_ready_in,
  output logic                      pkt_ok_out,
  output logic                      pkt_err_out,
  output logic [7:0]                err_count_out,
  output logic                      busy_out
);

  localparam int unsigned XW = $clog2(LENGTH);
  localparam int unsigned YW = $clog2(WIDTH);
  localparam int unsigned ZW = $clog2(HEIGHT);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RW = 9;

  ws_state_e             state, state_nxt;
  logic                  op_run, op_run_nxt;
  logic [7:0]            chk, chk_nxt;
  logic [7:0]            cnt, cnt_nxt;
  logic                  range_err, range_err_nxt;
  logic [XW-1:0]         x_start, x_start_nxt;
  logic [YW-1:0]         y_start, y_start_nxt;
  logic [ZW-1:0]         z_start, z_start_nxt;
  logic [BLOCK_BITS-1:0] blk, blk_nxt, block_nxt;
  logic [RW-1:0]         remaining, remaining_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  hold_valid, hold_valid_nxt;
  logic [7:0]            hold_byte, hold_byte_nxt;
  logic                  write_valid_nxt, pkt_ok_nxt, pkt_err_nxt;
  logic                  eff_valid;
  logic [7:0]            eff_byte;
  logic                  load, step, last_c;
  logic                  xfer;

  voxel_coord_stepper #(
    .LENGTH(LENGTH),
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_stepper (
    .clk    (clk_in),
    .rst_n  (rst_in),
    .load   (load),
    .step   (step),
    .x_start(x_start),
    .y_start(y_start),
    .z_start(z_start),
    .x      (x_out),
    .y      (y_out),
    .z      (z_out),
    .last_c (last_c)
  );

  assign xfer = write_valid_out && write_ready_in;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= ST_IDLE;
      op_run          <= 1'b0;
      chk             <= '0;
      cnt             <= '0;
      range_err       <= 1'b0;
      x_start         <= '0;
      y_start         <= '0;
      z_start         <= '0;
      blk             <= '0;
      remaining       <= '0;
      timer           <= '0;
      hold_valid      <= 1'b0;
      hold_byte       <= '0;
      block_out       <= '0;
      write_valid_out <= 1'b0;
      pkt_ok_out      <= 1'b0;
      pkt_err_out     <= 1'b0;
      busy_out        <= 1'b0;
      err_count_out   <= '0;
    end else begin
      state           <= state_nxt;
      op_run          <= op_run_nxt;
      chk             <= chk_nxt;
      cnt             <= cnt_nxt;
      range_err       <= range_err_nxt;
      x_start         <= x_start_nxt;
      y_start         <= y_start_nxt;
      z_start         <= z_start_nxt;
      blk             <= blk_nxt;
      remaining       <= remaining_nxt;
      timer           <= timer_nxt;
      hold_valid      <= hold_valid_nxt;
      hold_byte       <= hold_byte_nxt;
      block_out       <= block_nxt;
      write_valid_out <= write_valid_nxt;
      pkt_ok_out      <= pkt_ok_nxt;
      pkt_err_out     <= pkt_err_nxt;
      busy_out        <= (state_nxt != ST_IDLE);
      if (pkt_err_out && (err_count_out != 8'hFF)) err_count_out <= err_count_out + 8'd1;
    end
  end

  always_comb begin
    state_nxt       = state;
    op_run_nxt      = op_run;
    chk_nxt         = chk;
    cnt_nxt         = cnt;
    range_err_nxt   = range_err;
    x_start_nxt     = x_start;
    y_start_nxt     = y_start;
    z_start_nxt     = z_start;
    blk_nxt         = blk;
    remaining_nxt   = remaining;
    timer_nxt       = '0;
    hold_valid_nxt  = hold_valid;
    hold_byte_nxt   = hold_byte;
    block_nxt       = block_out;
    write_valid_nxt = write_valid_out;
    pkt_ok_nxt      = 1'b0;
    pkt_err_nxt     = 1'b0;
    eff_valid       = 1'b0;
    eff_byte        = byte_in;
    load            = 1'b0;
    step            = 1'b0;

    // One-entry hold buffer: fills during WRITE, drains (replays) in any other state.
    if (state == ST_WRITE) begin
      if (byte_valid_in) begin
        if (!hold_valid) begin
          hold_valid_nxt = 1'b1;
          hold_byte_nxt  = byte_in;
        end else begin
          pkt_err_nxt = 1'b1;
        end
      end
    end else begin
      eff_valid = hold_valid || byte_valid_in;
      eff_byte  = hold_valid ? hold_byte : byte_in;
      if (hold_valid) begin
        hold_valid_nxt = byte_valid_in;
        if (byte_valid_in) hold_byte_nxt = byte_in;
      end
    end

    case (state)
      ST_IDLE: begin
        if (eff_valid && (eff_byte == WS_SYNC)) begin
          state_nxt     = ST_OPC;
          chk_nxt       = '0;
          range_err_nxt = 1'b0;
        end
      end
      ST_OPC: begin
        if (eff_valid) begin
          if (is_valid_op(eff_byte)) begin
            op_run_nxt = (eff_byte == WS_OP_RUN);
            chk_nxt    = eff_byte;
            state_nxt  = ST_X;
          end else begin
            pkt_err_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_X: begin
        if (eff_valid) begin
          chk_nxt     = chk ^ eff_byte;
          x_start_nxt = XW'(eff_byte);
          if (32'(eff_byte) >= LENGTH) range_err_nxt = 1'b1;
          state_nxt   = ST_Y;
        end
      end
      ST_Y: begin
        if (eff_valid) begin
          chk_nxt     = chk ^ eff_byte;
          y_start_nxt = YW'(eff_byte);
          if (32'(eff_byte) >= WIDTH) range_err_nxt = 1'b1;
          state_nxt   = ST_Z;
        end
      end
      ST_Z: begin
        if (eff_valid) begin
          chk_nxt     = chk ^ eff_byte;
          z_start_nxt = ZW'(eff_byte);
          if (32'(eff_byte) >= HEIGHT) range_err_nxt = 1'b1;
          state_nxt   = op_run ? ST_CNT : ST_BLK;
        end
      end
      ST_CNT: begin
        if (eff_valid) begin
          chk_nxt   = chk ^ eff_byte;
          cnt_nxt   = eff_byte;
          state_nxt = ST_BLK;
        end
      end
      ST_BLK: begin
        if (eff_valid) begin
          chk_nxt   = chk ^ eff_byte;
          blk_nxt   = BLOCK_BITS'(eff_byte);
          state_nxt = ST_CHK;
        end
      end
      ST_CHK: begin
        if (eff_valid) begin
          if ((eff_byte != chk) || range_err) begin
            pkt_err_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else begin
            load            = 1'b1;
            block_nxt       = blk;
            write_valid_nxt = 1'b1;
            remaining_nxt   = op_run ? ((cnt == 8'd0) ? RW'(256) : RW'(cnt)) : RW'(1);
            state_nxt       = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        if (xfer) begin
          if (remaining == RW'(1)) begin
            write_valid_nxt = 1'b0;
            pkt_ok_nxt      = 1'b1;
            state_nxt       = ST_IDLE;
          end else if (last_c) begin
            write_valid_nxt = 1'b0;
            pkt_err_nxt     = 1'b1;
            state_nxt       = ST_IDLE;
          end else begin
            step          = 1'b1;
            remaining_nxt = remaining - RW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Inter-byte timeout applies only while a packet header/payload is in flight.
    if ((state != ST_IDLE) && (state != ST_WRITE) && !eff_valid) begin
      if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
        pkt_err_nxt = 1'b1;
        state_nxt   = ST_IDLE;
      end else begin
        timer_nxt = timer + TW'(1);
      end
    end
  end

endmodule
